// File: rtl/launch_sequencer_pkg.sv
// launch_sequencer_pkg
// Purpose: shared types and constants for the launch sequencer slice:
//          FSM state enum, playfield limits and coordinate/velocity widths.
// Ports:   none (package).
package launch_sequencer_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int VEL_W   = 5;
    localparam int FRAME_W = 10;

    localparam logic [X_W-1:0] X_MAX   = 9'd287;
    localparam logic [Y_W-1:0] Y_FLOOR = 8'd207;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRESET,
        S_LOAD,
        S_DRAW0,
        S_WAIT_TICK,
        S_ERASE,
        S_STEP,
        S_SAMPLE,
        S_DRAW,
        S_CHECK,
        S_FINISH
    } state_t;

endpackage

// File: rtl/launch_sequencer_if.sv
// launch_sequencer_if
// Purpose: sprite draw handshake between the sequencer (master) and the
//          sprite writer (slave).
// Signals: draw_req   - request, held until draw_done
//          draw_erase - 1 = erase, 0 = draw
//          draw_x/y   - sprite coordinates
//          draw_done  - one-cycle completion pulse from the writer
interface launch_sequencer_if;
    import launch_sequencer_pkg::*;

    logic           draw_req;
    logic           draw_erase;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_done;

    modport master (
        output draw_req,
        output draw_erase,
        output draw_x,
        output draw_y,
        input  draw_done
    );

    modport slave (
        input  draw_req,
        input  draw_erase,
        input  draw_x,
        input  draw_y,
        output draw_done
    );

endinterface

// File: rtl/launch_sequencer_sprite_req_ctrl.sv
// sprite_req_ctrl
// Purpose: one draw/erase request to the sprite writer. A start pulse latches
//          erase flag and coordinates and raises draw_req; everything holds
//          until draw_done, after which draw_req drops on the next cycle.
// Ports:   clk, reset_n (sync, active-low)
//          i_start, i_erase, i_x, i_y - request launch and its payload
//          i_draw_done               - completion from the writer
//          o_draw_req, o_draw_erase, o_draw_x, o_draw_y - request outputs
//          o_finished                - high in the cycle draw_done is accepted
module sprite_req_ctrl
    import launch_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_start,
    input  logic           i_erase,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic           i_draw_done,
    output logic           o_draw_req,
    output logic           o_draw_erase,
    output logic [X_W-1:0] o_draw_x,
    output logic [Y_W-1:0] o_draw_y,
    output logic           o_finished
);

    logic           r_req;
    logic           r_erase;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req   <= 1'b0;
            r_erase <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (r_req) begin
            if (i_draw_done)
                r_req <= 1'b0;
        end else if (i_start) begin
            r_req   <= 1'b1;
            r_erase <= i_erase;
            r_x     <= i_x;
            r_y     <= i_y;
        end
    end

    // A done pulse with no request outstanding is ignored.
    assign o_finished   = r_req & i_draw_done;
    assign o_draw_req   = r_req;
    assign o_draw_erase = r_erase;
    assign o_draw_x     = r_x;
    assign o_draw_y     = r_y;

endmodule

// File: rtl/launch_sequencer.sv
// launch_sequencer
// Purpose: sequences one projectile shot: resets and loads the physics block,
//          then per frame erases the sprite, steps physics and redraws, until
//          the position settles or the frame limit is hit.
// Ports:   clk, reset_n (sync, active-low)
//          i_launch, i_x_vel_cfg, i_y_vel_cfg - shot start and velocities
//          i_frame_tick, i_x_pos, i_y_pos     - frame strobe, physics position
//          draw_if (master)                   - sprite draw handshake
//          o_phys_rst_n, o_phys_load, o_phys_go, o_x_vel_out, o_y_vel_out
//          o_busy, o_done, o_frame_cnt
//          o_drop_cnt - only when LAUNCH_DROP_COUNT_EN is defined
// Optional: LAUNCH_DROP_COUNT_EN adds a saturating count of frame ticks
//           dropped while busy outside WAIT_TICK.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for launch
// PRESET    | physics reset pulse
// LOAD      | physics velocity load pulse
// DRAW0     | initial sprite draw
// WAIT_TICK | waiting for frame_tick
// ERASE     | erase sprite at last drawn position
// STEP      | physics step pulse
// SAMPLE    | wait for physics registers to update
// DRAW      | draw sprite at new position
// CHECK     | settle / frame-limit evaluation
// FINISH    | done pulse
module launch_sequencer
    import launch_sequencer_pkg::*;
#(
    parameter int MAX_FRAMES    = 600,
    parameter int SETTLE_FRAMES = 4
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_launch,
    input  logic [VEL_W-1:0]   i_x_vel_cfg,
    input  logic [VEL_W-1:0]   i_y_vel_cfg,
    input  logic               i_frame_tick,
    input  logic [X_W-1:0]     i_x_pos,
    input  logic [Y_W-1:0]     i_y_pos,
    launch_sequencer_if.master draw_if,
    output logic               o_phys_rst_n,
    output logic               o_phys_load,
    output logic               o_phys_go,
    output logic [VEL_W-1:0]   o_x_vel_out,
    output logic [VEL_W-1:0]   o_y_vel_out,
    output logic               o_busy,
    output logic               o_done,
`ifdef LAUNCH_DROP_COUNT_EN
    output logic [7:0]         o_drop_cnt,
`endif
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int STILL_W = $clog2(SETTLE_FRAMES + 1);
    localparam logic [STILL_W-1:0] STILL_MAX = STILL_W'(SETTLE_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(MAX_FRAMES);

    state_t             r_state;
    state_t             w_next;
    logic [VEL_W-1:0]   r_x_vel;
    logic [VEL_W-1:0]   r_y_vel;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [STILL_W-1:0] r_still_cnt;
    logic [STILL_W-1:0] w_still_next;
    logic [X_W-1:0]     r_last_x;
    logic [Y_W-1:0]     r_last_y;
    logic               r_same;
    logic               w_start;
    logic               w_erase;
    logic               w_finished;
    logic               w_launch_ok;
    logic [X_W-1:0]     w_req_x;
    logic [Y_W-1:0]     w_req_y;

    assign w_launch_ok = (r_state == S_IDLE) && i_launch;

    // Erase reuses the last drawn coordinates; draws take the live position.
    assign w_req_x = w_erase ? r_last_x : i_x_pos;
    assign w_req_y = w_erase ? r_last_y : i_y_pos;

    // Draw requests are launched on the transition into a draw state so that
    // draw_req is already high in the first cycle of that state.
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_erase      = 1'b0;
        w_still_next = r_still_cnt;
        case (r_state)
            S_IDLE:      if (i_launch) w_next = S_PRESET;
            S_PRESET:    w_next = S_LOAD;
            S_LOAD: begin
                w_next  = S_DRAW0;
                w_start = 1'b1;
            end
            S_DRAW0:     if (w_finished) w_next = S_WAIT_TICK;
            S_WAIT_TICK: if (i_frame_tick) begin
                w_next  = S_ERASE;
                w_start = 1'b1;
                w_erase = 1'b1;
            end
            S_ERASE:     if (w_finished) w_next = S_STEP;
            S_STEP:      w_next = S_SAMPLE;
            S_SAMPLE: begin
                w_next  = S_DRAW;
                w_start = 1'b1;
            end
            S_DRAW:      if (w_finished) w_next = S_CHECK;
            S_CHECK: begin
                if (!r_same)
                    w_still_next = '0;
                else if (r_still_cnt != STILL_MAX)
                    w_still_next = r_still_cnt + 1'b1;
                if ((w_still_next == STILL_MAX) || (r_frame_cnt == FRAME_MAX))
                    w_next = S_FINISH;
                else
                    w_next = S_WAIT_TICK;
            end
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_x_vel     <= '0;
            r_y_vel     <= '0;
            r_frame_cnt <= '0;
            r_still_cnt <= '0;
            r_last_x    <= '0;
            r_last_y    <= '0;
            r_same      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch_ok) begin
                r_x_vel     <= i_x_vel_cfg;
                r_y_vel     <= i_y_vel_cfg;
                r_frame_cnt <= '0;
                r_still_cnt <= '0;
            end
            if ((r_state == S_STEP) && (r_frame_cnt != FRAME_MAX))
                r_frame_cnt <= r_frame_cnt + 1'b1;
            if (r_state == S_CHECK)
                r_still_cnt <= w_still_next;
            // Compare against the previous draw before overwriting it.
            if (w_start && !w_erase) begin
                r_last_x <= i_x_pos;
                r_last_y <= i_y_pos;
                r_same   <= (i_x_pos == r_last_x) && (i_y_pos == r_last_y);
            end
        end
    end

    sprite_req_ctrl u_sprite_req_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (w_start),
        .i_erase      (w_erase),
        .i_x          (w_req_x),
        .i_y          (w_req_y),
        .i_draw_done  (draw_if.draw_done),
        .o_draw_req   (draw_if.draw_req),
        .o_draw_erase (draw_if.draw_erase),
        .o_draw_x     (draw_if.draw_x),
        .o_draw_y     (draw_if.draw_y),
        .o_finished   (w_finished)
    );

    // State-decoded strobes are gated by reset so they drop as soon as
    // reset_n is asserted; phys_rst_n follows reset directly.
    assign o_phys_rst_n = reset_n && (r_state != S_PRESET);
    assign o_phys_load  = reset_n && (r_state == S_LOAD);
    assign o_phys_go    = reset_n && (r_state == S_STEP);
    assign o_busy       = reset_n && (r_state != S_IDLE);
    assign o_done       = reset_n && (r_state == S_FINISH);
    assign o_x_vel_out  = r_x_vel;
    assign o_y_vel_out  = r_y_vel;
    assign o_frame_cnt  = r_frame_cnt;

`ifdef LAUNCH_DROP_COUNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_drop_cnt <= '0;
        else if (w_launch_ok)
            r_drop_cnt <= '0;
        else if (i_frame_tick && (r_state != S_IDLE) && (r_state != S_WAIT_TICK)
                 && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_launch_sequencer.sv
module tb_launch_sequencer;
    import launch_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       launch;
    logic       t_en;
    logic [4:0] x_cfg, y_cfg;
    logic       frame_tick;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic       draw_done;

    logic       phys_rst_n, phys_load, phys_go, busy, done;
    logic [4:0] x_vel, y_vel;
    logic [9:0] frame_cnt;
    logic       t_phys_rst_n, t_phys_load, t_phys_go, t_busy, t_done;
    logic [4:0] t_x_vel, t_y_vel;
    logic [9:0] t_frame_cnt;
`ifdef LAUNCH_DROP_COUNT_EN
    logic [7:0] drop_cnt, t_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int go_cnt   = 0;
    int done_cnt = 0;

    launch_sequencer_if dif();
    launch_sequencer_if tif();
    assign dif.draw_done = draw_done;
    assign tif.draw_done = draw_done;

    always #5 clk = ~clk;

    launch_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_launch     (launch),
        .i_x_vel_cfg  (x_cfg),
        .i_y_vel_cfg  (y_cfg),
        .i_frame_tick (frame_tick),
        .i_x_pos      (x_pos),
        .i_y_pos      (y_pos),
        .draw_if      (dif.master),
        .o_phys_rst_n (phys_rst_n),
        .o_phys_load  (phys_load),
        .o_phys_go    (phys_go),
        .o_x_vel_out  (x_vel),
        .o_y_vel_out  (y_vel),
        .o_busy       (busy),
        .o_done       (done),
`ifdef LAUNCH_DROP_COUNT_EN
        .o_drop_cnt   (drop_cnt),
`endif
        .o_frame_cnt  (frame_cnt)
    );

    // Short frame limit copy for the timeout scenario; launch gated by t_en.
    launch_sequencer #(.MAX_FRAMES(3)) dut_t (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_launch     (launch & t_en),
        .i_x_vel_cfg  (x_cfg),
        .i_y_vel_cfg  (y_cfg),
        .i_frame_tick (frame_tick),
        .i_x_pos      (x_pos),
        .i_y_pos      (y_pos),
        .draw_if      (tif.master),
        .o_phys_rst_n (t_phys_rst_n),
        .o_phys_load  (t_phys_load),
        .o_phys_go    (t_phys_go),
        .o_x_vel_out  (t_x_vel),
        .o_y_vel_out  (t_y_vel),
        .o_busy       (t_busy),
        .o_done       (t_done),
`ifdef LAUNCH_DROP_COUNT_EN
        .o_drop_cnt   (t_drop_cnt),
`endif
        .o_frame_cnt  (t_frame_cnt)
    );

    always @(posedge clk) begin
        if (phys_go) go_cnt <= go_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered in the first cycle of a draw state; holds one cycle, then completes.
    task automatic do_draw(input logic er, input logic [8:0] ex, input logic [7:0] ey,
                           input logic inject);
        chk("draw_req", {31'd0, dif.draw_req}, 1);
        chk("draw_erase", {31'd0, dif.draw_erase}, {31'd0, er});
        chk("draw_x", {23'd0, dif.draw_x}, {23'd0, ex});
        chk("draw_y", {24'd0, dif.draw_y}, {24'd0, ey});
        if (inject) begin
            launch     = 1'b1;
            frame_tick = 1'b1;
            x_cfg      = 5'd7;
            y_cfg      = 5'd3;
        end
        tick();
        launch     = 1'b0;
        frame_tick = 1'b0;
        chk("draw_hold_req", {31'd0, dif.draw_req}, 1);
        chk("draw_hold_x", {23'd0, dif.draw_x}, {23'd0, ex});
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("draw_release", {31'd0, dif.draw_req}, 0);
    endtask

    // Entered in WAIT_TICK; returns in CHECK.
    task automatic run_frame(input logic [8:0] nx, input logic [7:0] ny,
                             input logic [8:0] ox, input logic [7:0] oy,
                             input logic [9:0] exp_frame, input logic inject);
        chk("wait_req_low", {31'd0, dif.draw_req}, 0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        do_draw(1'b1, ox, oy, inject);
        chk("step_go", {31'd0, phys_go}, 1);
        tick();
        chk("sample_go", {31'd0, phys_go}, 0);
        chk("frame_cnt", {22'd0, frame_cnt}, {22'd0, exp_frame});
        x_pos = nx;
        y_pos = ny;
        tick();
        do_draw(1'b0, nx, ny, 1'b0);
        chk("check_done", {31'd0, done}, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        launch     = 1'b0;
        t_en       = 1'b1;
        x_cfg      = '0;
        y_cfg      = '0;
        frame_tick = 1'b0;
        draw_done  = 1'b0;
        x_pos      = 9'd0;
        y_pos      = Y_FLOOR;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_phys_rst_n", {31'd0, phys_rst_n}, 0);
        chk("rst_draw_req", {31'd0, dif.draw_req}, 0);
        chk("rst_frame_cnt", {22'd0, frame_cnt}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_x_vel", {27'd0, x_vel}, 0);
        reset_n = 1'b1;
        #1;
        chk("idle_phys_rst_n", {31'd0, phys_rst_n}, 1);
        tick();
        chk("idle_busy", {31'd0, busy}, 0);

        // Launch: PRESET, LOAD, DRAW0 at (0, Y_FLOOR)
        x_cfg  = 5'd5;
        y_cfg  = 5'd10;
        launch = 1'b1;
        tick();
        launch = 1'b0;
        chk("preset_phys_rst_n", {31'd0, phys_rst_n}, 0);
        chk("preset_load", {31'd0, phys_load}, 0);
        chk("preset_busy", {31'd0, busy}, 1);
        tick();
        chk("load_phys_rst_n", {31'd0, phys_rst_n}, 1);
        chk("load_strobe", {31'd0, phys_load}, 1);
        chk("load_x_vel", {27'd0, x_vel}, 5);
        chk("load_y_vel", {27'd0, y_vel}, 10);
        tick();
        chk("draw0_load_low", {31'd0, phys_load}, 0);
        do_draw(1'b0, 9'd0, Y_FLOOR, 1'b0);

        // Stray draw_done with no request pending
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("stray_done_req", {31'd0, dif.draw_req}, 0);
        chk("no_go_yet", go_cnt, 0);

        // Moving frames 1..3; the MAX_FRAMES=3 copy times out after frame 3
        run_frame(9'd5, 8'd197, 9'd0, Y_FLOOR, 10'd1, 1'b0);
        chk("go_after_f1", go_cnt, 1);
        tick();
        run_frame(9'd10, 8'd187, 9'd5, 8'd197, 10'd2, 1'b0);
        tick();
        chk("t_done_f2", {31'd0, t_done}, 0);
        chk("t_busy_f2", {31'd0, t_busy}, 1);
        run_frame(9'd15, 8'd177, 9'd10, 8'd187, 10'd3, 1'b0);
        chk("t_frame_cnt", {22'd0, t_frame_cnt}, 3);
        tick();
        chk("t_done_pulse", {31'd0, t_done}, 1);
        chk("main_no_done", {31'd0, done}, 0);
        chk("main_busy", {31'd0, busy}, 1);
        tick();
        chk("t_done_clear", {31'd0, t_done}, 0);
        chk("t_busy_clear", {31'd0, t_busy}, 0);
        t_en = 1'b0;

        // Frame 4 with launch + frame_tick injected during ERASE; position now still
        run_frame(9'd15, 8'd177, 9'd15, 8'd177, 10'd4, 1'b1);
        chk("drop_go_cnt", go_cnt, 4);
        chk("drop_x_vel", {27'd0, x_vel}, 5);
        chk("drop_y_vel", {27'd0, y_vel}, 10);
`ifdef LAUNCH_DROP_COUNT_EN
        chk("drop_cnt", {24'd0, drop_cnt}, 1);
`endif
        tick();
        run_frame(9'd15, 8'd177, 9'd15, 8'd177, 10'd5, 1'b0);
        tick();
        run_frame(9'd15, 8'd177, 9'd15, 8'd177, 10'd6, 1'b0);
        tick();
        run_frame(9'd15, 8'd177, 9'd15, 8'd177, 10'd7, 1'b0);
        tick();
        chk("settle_done", {31'd0, done}, 1);
        chk("settle_busy", {31'd0, busy}, 1);
        tick();
        chk("settle_done_clear", {31'd0, done}, 0);
        chk("settle_idle", {31'd0, busy}, 0);
        chk("settle_sprite_kept", {31'd0, dif.draw_req}, 0);
        chk("settle_frame_cnt", {22'd0, frame_cnt}, 7);
        chk("settle_done_cnt", done_cnt, 1);
        chk("settle_go_cnt", go_cnt, 7);

        // Second shot, reset during DRAW with draw_req high
        x_cfg  = 5'd3;
        y_cfg  = 5'd4;
        launch = 1'b1;
        tick();
        launch = 1'b0;
`ifdef LAUNCH_DROP_COUNT_EN
        chk("drop_cnt_cleared", {24'd0, drop_cnt}, 0);
`endif
        tick();
        chk("shot2_x_vel", {27'd0, x_vel}, 3);
        tick();
        do_draw(1'b0, 9'd15, 8'd177, 1'b0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        do_draw(1'b1, 9'd15, 8'd177, 1'b0);
        tick();
        x_pos = 9'd20;
        y_pos = 8'd170;
        tick();
        chk("mid_draw_req", {31'd0, dif.draw_req}, 1);
        chk("mid_draw_x", {23'd0, dif.draw_x}, 20);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_phys_rst_n", {31'd0, phys_rst_n}, 0);
        tick();
        chk("mid_rst_req", {31'd0, dif.draw_req}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_frame_cnt", {22'd0, frame_cnt}, 0);
        chk("mid_rst_x_vel", {27'd0, x_vel}, 0);
        chk("mid_rst_draw_x", {23'd0, dif.draw_x}, 0);
        reset_n   = 1'b1;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        repeat (4) tick();
        chk("post_rst_no_erase", {31'd0, dif.draw_req}, 0);
        chk("post_rst_idle", {31'd0, busy}, 0);
        chk("post_rst_done_cnt", done_cnt, 1);
        chk("post_rst_go_cnt", go_cnt, 8);
        chk("post_rst_phys_rst_n", {31'd0, phys_rst_n}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/launch_sequencer.md
LAUNCH_SEQUENCER -- requirements
Module: launch_sequencer

Interface
REQ-001 Parameter MAX_FRAMES, default 600: frame limit per shot before forced finish.
REQ-002 Parameter SETTLE_FRAMES, default 4: count of consecutive unchanged-position steps that ends a shot.
REQ-003 clk  in  1  clock; reset_n is synchronous, active-low; clock is clk.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 launch  in  1  start pulse; ignored while busy.
REQ-006 x_vel_cfg, y_vel_cfg  in  5 each  launch velocities, captured on the accepted launch.
REQ-007 frame_tick  in  1  one-cycle frame strobe.
REQ-008 x_pos  in  9, y_pos  in  8  current physics position.
REQ-009 draw_done  in  1  one-cycle completion pulse from the sprite writer.
REQ-010 phys_rst_n  out  1  physics reset, active-low.
REQ-011 phys_load  out  1  physics velocity load strobe.
REQ-012 phys_go  out  1  physics step strobe.
REQ-013 x_vel_out, y_vel_out  out  5 each  captured velocities.
REQ-014 draw_req  out  1  sprite request; draw_erase  out  1  1=erase, 0=draw.
REQ-015 draw_x  out  9, draw_y  out  8  sprite coordinates.
REQ-016 busy  out  1  high outside IDLE.
REQ-017 done  out  1  one-cycle end-of-shot pulse.
REQ-018 frame_cnt  out  10  steps taken in the current shot.

Function
REQ-019 States: IDLE, PRESET, LOAD, DRAW0, WAIT_TICK, ERASE, STEP, SAMPLE, DRAW, CHECK, FINISH.
REQ-020 IDLE plus launch: capture x_vel_cfg and y_vel_cfg, clear frame_cnt and still_cnt, go to PRESET.
REQ-021 PRESET: phys_rst_n low for exactly 1 cycle, then go to LOAD. Reset and load are kept in separate cycles because physics reset overrides load.
REQ-022 LOAD: phys_load high for 1 cycle, then go to DRAW0.
REQ-023 DRAW0: draw the sprite at the current x_pos/y_pos with draw_erase=0, then go to WAIT_TICK.
REQ-024 Draw handshake: draw_req, draw_x, draw_y and draw_erase stay stable from state entry until draw_done is sampled high; draw_req is low on the cycle after draw_done.
REQ-025 A draw_done that arrives while draw_req is low is ignored.
REQ-026 WAIT_TICK plus frame_tick: go to ERASE, which erases the sprite at the last drawn coordinates.
REQ-027 STEP: phys_go high for exactly 1 cycle; frame_cnt increments.
REQ-028 SAMPLE: 1 wait cycle so the physics registers can update, then go to DRAW at the new x_pos/y_pos.
REQ-029 CHECK, settle counting: if the new position equals the last drawn position, still_cnt increments (saturating); otherwise still_cnt clears.
REQ-030 CHECK, exits: go to FINISH if still_cnt reaches SETTLE_FRAMES or frame_cnt reaches MAX_FRAMES; otherwise go to WAIT_TICK.
REQ-031 FINISH: done high for 1 cycle, then go to IDLE. The sprite remains drawn.
REQ-032 A frame_tick outside WAIT_TICK is dropped and does not queue.
REQ-033 A launch while busy is dropped.
REQ-034 No arithmetic wraps: frame_cnt stops at MAX_FRAMES and still_cnt saturates.

Reset
REQ-035 When reset_n is low at any state: state goes to IDLE and every output goes low.
REQ-036 Exceptions to REQ-035: phys_rst_n is low during reset and high afterwards outside PRESET.
REQ-037 Reset mid-handshake drops draw_req on the next cycle; no erase is issued.

Configuration
REQ-038 Macro LAUNCH_DROP_COUNT_EN, when defined: adds output drop_cnt (8 bits), incremented for each frame_tick seen while busy and outside WAIT_TICK.
REQ-039 drop_cnt saturates at 255 and clears on launch acceptance and on reset.
REQ-040 Without LAUNCH_DROP_COUNT_EN, the drop_cnt port and its logic are absent.

Structure
REQ-041 A shared package holds the state enum typedef, the X_MAX=287 and Y_FLOOR=207 constants, and the coordinate widths.
REQ-042 The draw handshake is one sub-module, sprite_req_ctrl, with inputs start, erase and coordinates, and outputs draw_req and finished.

Verification
REQ-043 Launch scenario: launch with x_vel_cfg=5, y_vel_cfg=10. Required: phys_rst_n low 1 cycle, then phys_load 1 cycle with x_vel_out=5 and y_vel_out=10, then draw_req with draw_erase=0 at (0,207).
REQ-044 Frame-step scenario: frame_tick while in WAIT_TICK. Required: erase at the old coordinates, then exactly one phys_go pulse, then draw at the new coordinates; frame_cnt=1.
REQ-045 Settle scenario: x_pos/y_pos held constant for 4 steps. Required: done pulse after the 4th CHECK, busy low on the next cycle.
REQ-046 Timeout scenario: MAX_FRAMES=3 with a moving position. Required: done after frame_cnt=3.
REQ-047 Drop scenario: launch and frame_tick asserted during ERASE. Required: both ignored, no extra phys_go; with LAUNCH_DROP_COUNT_EN, drop_cnt=1.
REQ-048 Reset scenario: reset_n low during DRAW with draw_req high. Required: draw_req low next cycle, state IDLE, done never pulses.
